// File: rtl/keypad_input.sv
// keypad_input: scans a 4x4 active-low matrix keypad, debounces one key at a
// time and shifts six hex digits into a 24-bit value that the CPU reads on a
// 32-bit bus. The CPU acknowledges the completed value to start a new entry.
module keypad_input #(
   parameter int unsigned SCAN_DIV        = 32'h7FFF,
   parameter int unsigned DEBOUNCE_FRAMES = 4
) (
   input  logic        i_SYS_CLOCK,
   input  logic        i_CLEAR_n,
   output logic [3:0]  o_ROW_n,
   input  logic [3:0]  i_COL_n,
   input  logic        i_WRITE_BUS,
   output logic [31:0] o_BUS,
   output logic        o_READY,
   input  logic        i_ACK,
   output logic        o_KEY_PULSE
);

   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
   // Both the press and the release side need DEBOUNCE_FRAMES identical frames;
   // the frame that enters the check state is the first of them.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_FRAMES - 1);
   localparam logic [31:0]      DIV_MAX  = 32'(SCAN_DIV);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_CHK,
      ST_HELD,
      ST_REL_CHK
   } state_t;

   // Scan timing and column sampling
   logic [31:0]      presc_reg;
   logic             tick;
   logic [1:0]       row_idx_reg;
   logic [3:0]       col_meta_reg;
   logic [3:0]       col_sync_reg;
   logic [3:0]       col_active;
   logic [11:0]      frame_bits_reg;
   logic [15:0]      frame_now;
   logic             frame_valid;
   logic [1:0]       hit_count;
   logic [3:0]       hit_code;
   logic             frame_key;
   logic             frame_none;

   // Debounce FSM
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
   logic [CNT_W-1:0] frame_cnt_inc;
   logic [3:0]       cand_reg, cand_next;
   logic             accept;

   // Digit entry datapath
   logic [23:0]      value_reg;
   logic [2:0]       digit_cnt_reg;
   logic             ready_reg;
   logic             pulse_reg;

   assign tick        = (presc_reg == DIV_MAX);
   assign frame_valid = tick && (row_idx_reg == 2'd3);
   assign col_active  = ~col_sync_reg;
   // Rows 0..2 were latched on earlier ticks; row 3 is still on the wires.
   assign frame_now   = {col_active, frame_bits_reg};

   // Prescaler producing a one-cycle scan tick every SCAN_DIV+1 clocks
   always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
      if (!i_CLEAR_n) begin
         presc_reg <= '0;
      end else if (tick) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_reg + 32'd1;
      end
   end

   // Two-flop synchroniser on the asynchronous column inputs
   always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
      if (!i_CLEAR_n) begin
         col_meta_reg <= 4'hF;
         col_sync_reg <= 4'hF;
      end else begin
         col_meta_reg <= i_COL_n;
         col_sync_reg <= col_meta_reg;
      end
   end

   // Row rotation and per-row column capture on every tick
   always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
      if (!i_CLEAR_n) begin
         row_idx_reg    <= 2'd0;
         frame_bits_reg <= '0;
      end else if (tick) begin
         row_idx_reg <= row_idx_reg + 2'd1;
         case (row_idx_reg)
            2'd0:    frame_bits_reg[3:0]  <= col_active;
            2'd1:    frame_bits_reg[7:4]  <= col_active;
            2'd2:    frame_bits_reg[11:8] <= col_active;
            default: frame_bits_reg       <= frame_bits_reg;
         endcase
      end
   end

   // One-hot active-low row drive from the row index
   always_comb begin
      o_ROW_n = ~(4'b0001 << row_idx_reg);
   end

   // Frame classification: exactly one closed switch is a key, else nothing.
   // Bit position row*4+col is directly the key code {row, col}.
   always_comb begin
      hit_count = 2'd0;
      hit_code  = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (frame_now[i]) begin
            if (hit_count != 2'd2) begin
               hit_count = hit_count + 2'd1;
            end
            hit_code = 4'(i);
         end
      end
   end

   assign frame_key  = frame_valid && (hit_count == 2'd1);
   assign frame_none = frame_valid && !frame_key;

   // Debounce FSM state, frame counter and candidate code registers
   always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
      if (!i_CLEAR_n) begin
         state_reg     <= ST_IDLE;
         frame_cnt_reg <= '0;
         cand_reg      <= 4'd0;
      end else begin
         state_reg     <= state_next;
         frame_cnt_reg <= frame_cnt_next;
         cand_reg      <= cand_next;
      end
   end

   assign frame_cnt_inc = frame_cnt_reg + CNT_W'(1);

   // Debounce next-state logic; only frame results move the FSM
   always_comb begin
      state_next     = state_reg;
      frame_cnt_next = frame_cnt_reg;
      cand_next      = cand_reg;
      accept         = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (frame_key) begin
               cand_next      = hit_code;
               frame_cnt_next = '0;
               state_next     = ST_PRESS_CHK;
            end
         end
         ST_PRESS_CHK: begin
            if (frame_valid) begin
               if (frame_key && (hit_code == cand_reg)) begin
                  if (frame_cnt_inc >= LAST_CNT) begin
                     accept         = 1'b1;
                     frame_cnt_next = '0;
                     state_next     = ST_HELD;
                  end else begin
                     frame_cnt_next = frame_cnt_inc;
                  end
               end else begin
                  frame_cnt_next = '0;
                  state_next     = ST_IDLE;
               end
            end
         end
         ST_HELD: begin
            // No auto-repeat: a held key just sits here until released.
            if (frame_none) begin
               frame_cnt_next = '0;
               state_next     = ST_REL_CHK;
            end
         end
         ST_REL_CHK: begin
            if (frame_key) begin
               frame_cnt_next = '0;
               state_next     = ST_HELD;
            end else if (frame_none) begin
               if (frame_cnt_inc >= LAST_CNT) begin
                  frame_cnt_next = '0;
                  state_next     = ST_IDLE;
               end else begin
                  frame_cnt_next = frame_cnt_inc;
               end
            end
         end
         default: begin
            frame_cnt_next = '0;
            state_next     = ST_IDLE;
         end
      endcase
   end

   // Digit shift register, digit count, ready flag and key strobe.
   // Accepts are ignored while ready, so they never collide with an ACK.
   always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
      if (!i_CLEAR_n) begin
         value_reg     <= 24'h0;
         digit_cnt_reg <= 3'd0;
         ready_reg     <= 1'b0;
         pulse_reg     <= 1'b0;
      end else begin
         pulse_reg <= 1'b0;
         if (accept && !ready_reg) begin
            value_reg     <= {value_reg[19:0], cand_reg};
            digit_cnt_reg <= digit_cnt_reg + 3'd1;
            ready_reg     <= (digit_cnt_reg == 3'd5);
            pulse_reg     <= 1'b1;
         end else if (i_ACK && ready_reg) begin
            value_reg     <= 24'h0;
            digit_cnt_reg <= 3'd0;
            ready_reg     <= 1'b0;
         end
      end
   end

   // Bus is driven only while the CPU asks for it
   always_comb begin
      o_BUS = 32'h0;
      if (i_WRITE_BUS) begin
         o_BUS = {8'h00, value_reg};
      end
   end

   assign o_READY     = ready_reg;
   assign o_KEY_PULSE = pulse_reg;

endmodule

// File: tb/tb_keypad_input.sv
// tb_keypad_input: directed vector bench for keypad_input with a behavioural
// 4x4 switch matrix. Key changes are applied just after a frame boundary so
// every frame sees a clean, fully settled key pattern.
module tb_keypad_input;

   localparam int SCAN_DIV = 3;
   localparam int DEB      = 2;

   logic        clk = 1'b0;
   logic        clear_n;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic        write_bus;
   logic [31:0] bus;
   logic        ready;
   logic        ack;
   logic        key_pulse;
   logic [15:0] keys;

   int n_vec       = 0;
   int n_miss      = 0;
   int pulse_count = 0;

   typedef struct {
      logic [15:0] keys;
      int          frames;
      int          pulses;
      logic [31:0] bus;
      logic        ready;
   } vec_t;

   vec_t vecs[28];

   always #5 clk = ~clk;

   keypad_input #(
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_FRAMES (DEB)
   ) dut (
      .i_SYS_CLOCK (clk),
      .i_CLEAR_n   (clear_n),
      .o_ROW_n     (row_n),
      .i_COL_n     (col_n),
      .i_WRITE_BUS (write_bus),
      .o_BUS       (bus),
      .o_READY     (ready),
      .i_ACK       (ack),
      .o_KEY_PULSE (key_pulse)
   );

   // Switch matrix: a closed switch pulls its column low while its row is driven.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row_n[r] && keys[r*4+c]) begin
               col_n[c] = 1'b0;
            end
         end
      end
   end

   // Count key strobes, sampled away from the active edge
   always @(negedge clk) begin
      if (key_pulse) pulse_count++;
   end

   function automatic logic [15:0] k(input int code);
      logic [15:0] one;
      one = 16'h0001;
      return one << code;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Return on the negedge just after the row-3 tick that closes a frame
   task automatic next_frame();
      int n;
      n = 0;
      while (row_n != 4'b0111 && n < 64) begin
         @(negedge clk);
         n++;
      end
      while (row_n != 4'b1110 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         n_vec++;
         n_miss++;
         $display("FAIL frame_timeout: got no frame boundary within %0d cycles, expected one", n);
      end
   endtask

   task automatic align();
      next_frame();
      #1;
   endtask

   task automatic run_vectors(input int lo, input int hi);
      int p0;
      for (int i = lo; i <= hi; i++) begin
         keys = vecs[i].keys;
         p0   = pulse_count;
         repeat (vecs[i].frames) next_frame();
         #1;
         $display("vec %0d: keys=%h frames=%0d pulses=%0d bus=%h ready=%b",
                  i, vecs[i].keys, vecs[i].frames, pulse_count - p0, bus, ready);
         check($sformatf("vec%0d_pulses", i), 32'(pulse_count - p0), 32'(vecs[i].pulses));
         check($sformatf("vec%0d_bus", i), bus, vecs[i].bus);
         check($sformatf("vec%0d_ready", i), {31'd0, ready}, {31'd0, vecs[i].ready});
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;

      // six-digit entry, then a key while ready
      vecs[0]  = '{k(1),    2, 1, 32'h00000001, 1'b0};
      vecs[1]  = '{16'h0,   2, 0, 32'h00000001, 1'b0};
      vecs[2]  = '{k(2),    2, 1, 32'h00000012, 1'b0};
      vecs[3]  = '{16'h0,   2, 0, 32'h00000012, 1'b0};
      vecs[4]  = '{k(3),    2, 1, 32'h00000123, 1'b0};
      vecs[5]  = '{16'h0,   2, 0, 32'h00000123, 1'b0};
      vecs[6]  = '{k(10),   2, 1, 32'h0000123A, 1'b0};
      vecs[7]  = '{16'h0,   2, 0, 32'h0000123A, 1'b0};
      vecs[8]  = '{k(11),   2, 1, 32'h000123AB, 1'b0};
      vecs[9]  = '{16'h0,   2, 0, 32'h000123AB, 1'b0};
      vecs[10] = '{k(12),   2, 1, 32'h00123ABC, 1'b1};
      vecs[11] = '{16'h0,   2, 0, 32'h00123ABC, 1'b1};
      vecs[12] = '{k(5),    2, 0, 32'h00123ABC, 1'b1};
      vecs[13] = '{16'h0,   2, 0, 32'h00123ABC, 1'b1};
      // long hold, ghosting, bounce
      vecs[14] = '{k(9),    3, 1, 32'h00000009, 1'b0};
      vecs[15] = '{16'h0,   2, 0, 32'h00000009, 1'b0};
      vecs[16] = '{k(0) | k(5), 3, 0, 32'h00000009, 1'b0};
      vecs[17] = '{16'h0,   2, 0, 32'h00000009, 1'b0};
      vecs[18] = '{k(5),    1, 0, 32'h00000009, 1'b0};
      vecs[19] = '{16'h0,   1, 0, 32'h00000009, 1'b0};
      vecs[20] = '{k(5),    1, 0, 32'h00000009, 1'b0};
      vecs[21] = '{k(5),    1, 1, 32'h00000095, 1'b0};
      vecs[22] = '{k(5),   20, 0, 32'h00000095, 1'b0};
      vecs[23] = '{16'h0,   2, 0, 32'h00000095, 1'b0};
      // build 0x42 before the mid-debounce reset
      vecs[24] = '{k(4),    2, 1, 32'h00000004, 1'b0};
      vecs[25] = '{16'h0,   2, 0, 32'h00000004, 1'b0};
      vecs[26] = '{k(2),    2, 1, 32'h00000042, 1'b0};
      vecs[27] = '{16'h0,   2, 0, 32'h00000042, 1'b0};

      clear_n   = 1'b0;
      write_bus = 1'b1;
      ack       = 1'b0;
      keys      = 16'h0;

      repeat (3) @(posedge clk);
      #2;
      check("rst_row", {28'd0, row_n}, 32'h0000000E);
      check("rst_bus", bus, 32'h0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_pulse", {31'd0, key_pulse}, 32'd0);
      @(negedge clk);
      clear_n = 1'b1;
      align();

      run_vectors(0, 13);

      // ACK while ready clears the value on the next edge
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      $display("ack: bus=%h ready=%b", bus, ready);
      check("ack_bus", bus, 32'h0);
      check("ack_ready", {31'd0, ready}, 32'd0);
      align();

      run_vectors(14, 23);

      // ACK while not ready has no effect
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      $display("ack_not_ready: bus=%h ready=%b", bus, ready);
      check("ack_idle_bus", bus, 32'h00000095);
      write_bus = 1'b0;
      #1;
      check("bus_off", bus, 32'h0);
      write_bus = 1'b1;

      // plain reset pulse to start a fresh entry
      clear_n = 1'b0;
      #3;
      check("rst2_bus", bus, 32'h0);
      @(negedge clk);
      clear_n = 1'b1;
      align();

      run_vectors(24, 27);

      // reset in the middle of a press check
      keys = k(7);
      p0   = pulse_count;
      next_frame();
      #1;
      check("presschk_pulses", 32'(pulse_count - p0), 32'd0);
      @(posedge clk);
      #2;
      clear_n = 1'b0;
      #1;
      $display("async_reset: bus=%h row=%b ready=%b", bus, row_n, ready);
      check("async_rst_bus", bus, 32'h0);
      check("async_rst_row", {28'd0, row_n}, 32'h0000000E);
      check("async_rst_ready", {31'd0, ready}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      clear_n = 1'b1;
      p0 = pulse_count;
      repeat (3) @(negedge clk);
      #1;
      check("first_tick_pre_row", {28'd0, row_n}, 32'h0000000E);
      @(negedge clk);
      #1;
      check("first_tick_row", {28'd0, row_n}, 32'h0000000D);
      next_frame();
      #1;
      check("fresh_frame1_pulses", 32'(pulse_count - p0), 32'd0);
      next_frame();
      #1;
      $display("fresh_debounce: pulses=%0d bus=%h", pulse_count - p0, bus);
      check("fresh_frame2_pulses", 32'(pulse_count - p0), 32'd1);
      check("fresh_bus", bus, 32'h00000007);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/keypad_input.md
KEYPAD_INPUT -- requirements
Module: keypad_input

Interface
REQ-001 Parameter SCAN_DIV, default 32'h7FFF: scan tick period is SCAN_DIV+1 i_SYS_CLOCK cycles.
REQ-002 Parameter DEBOUNCE_FRAMES, default 4: number of consecutive identical scan frames that confirm a press or release.
REQ-003 i_SYS_CLOCK  in  1  system clock; the single clock for all logic.
REQ-004 i_CLEAR_n  in  1  reset; asynchronous, active-low.
REQ-005 o_ROW_n  out  4  keypad row drive, one-hot active-low.
REQ-006 i_COL_n  in  4  keypad column sense, active-low (pulled up externally); must be two-flop synchronised before use.
REQ-007 i_WRITE_BUS  in  1  CPU request to place the entered value on o_BUS.
REQ-008 o_BUS  out  32  {8'h00, r_VALUE} while i_WRITE_BUS=1, else 32'h0 (combinational).
REQ-009 o_READY  out  1  six digits entered, value complete.
REQ-010 i_ACK  in  1  CPU acknowledge; sampled synchronously.
REQ-011 o_KEY_PULSE  out  1  one-cycle strobe per accepted key.

Function
REQ-012 Prescaler counts 0..SCAN_DIV; scan tick asserts for one cycle when the count equals SCAN_DIV, then the count wraps to 0.
REQ-013 On each tick: latch the synchronised columns for the current row, then rotate o_ROW_n 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-014 A frame is four ticks (rows 0..3); the frame result is evaluated on the row-3 tick.
REQ-015 Frame result: exactly one active column across all rows gives KEY with code = {row[1:0], col[1:0]}; zero active gives NONE; two or more gives NONE (ghosting rejection).
REQ-016 Debounce FSM states: IDLE, PRESS_CHK, HELD, REL_CHK.
REQ-017 IDLE: a KEY frame loads the candidate code, clears the frame counter, and moves to PRESS_CHK.
REQ-018 PRESS_CHK: a frame matching the candidate increments the counter; when the counter reaches DEBOUNCE_FRAMES-1, accept the key and move to HELD. A mismatch or NONE frame returns to IDLE.
REQ-019 HELD: a NONE frame moves to REL_CHK with counter 0. No auto-repeat.
REQ-020 REL_CHK: a NONE frame increments the counter; DEBOUNCE_FRAMES consecutive NONE frames return to IDLE. Any KEY frame returns to HELD.
REQ-021 Accept while o_READY=0: r_VALUE <= {r_VALUE[19:0], code}; digit count +1; o_KEY_PULSE=1 for exactly one cycle.
REQ-022 Accept while o_READY=1: the key is discarded, with no pulse and no change to value or count; the FSM still moves to HELD.
REQ-023 o_READY asserts on the cycle after the accept that brings the count to 6; the count saturates at 6.
REQ-024 i_ACK=1 while o_READY=1: on the next edge, r_VALUE=0, count=0, o_READY=0. i_ACK while not ready is ignored.
REQ-025 i_ACK and an accept cannot collide, because accepts are discarded while ready. i_WRITE_BUS has no side effects.

Reset
REQ-026 While i_CLEAR_n=0, all of the following hold immediately, independent of the clock:
- o_ROW_n=4'b1110, prescaler=0, FSM=IDLE, frame counter=0
- r_VALUE=24'h0, count=0, o_READY=0, o_KEY_PULSE=0
- o_BUS=32'h0 unless i_WRITE_BUS=1 (then 32'h00000000)
REQ-027 Reset asserted mid-frame or mid-debounce abandons all partial state. The first tick after release occurs SCAN_DIV+1 cycles later.

Verification (SCAN_DIV=3, DEBOUNCE_FRAMES=2)
REQ-028 Hold row 2 / col 1 (code 4'h9) stable for 3 frames -> exactly one o_KEY_PULSE; r_VALUE=24'h000009; o_BUS=32'h00000009 with i_WRITE_BUS=1.
REQ-029 Enter keys 1,2,3,A,B,C, releasing for 2 frames between each -> after the 6th accept, o_READY=1 and r_VALUE=24'h123ABC. A 7th key gives no pulse and r_VALUE is unchanged. Pulse i_ACK -> next cycle r_VALUE=0, o_READY=0.
REQ-030 Key 5 bounces (KEY, NONE, KEY, KEY frames) -> one accept, only after the final two matching frames. Holding the key for 20 frames produces no further pulses.
REQ-031 Keys 0 and 5 pressed together -> NONE; no pulse; r_VALUE unchanged.
REQ-032 Assert i_CLEAR_n=0 mid-PRESS_CHK with r_VALUE=24'h000042 -> r_VALUE=0 and o_ROW_n=4'b1110 with no clock edge; after release, the held key requires a full fresh debounce.
